rc6_data_in_loader: RTL



---
 rtl/rc6_pkg.sv | 29 ++
 rtl/rc6_lane_writer.sv | 30 +++
 rtl/rc6_data_in_loader.sv | 73 +++++++
 3 files changed

// File: rtl/rc6_pkg.sv
// Shared RC6 constants, loader state type and byte-lane mapping.
// Ports: none (package).
package rc6_pkg;

  localparam int RC6_BLOCK_W = 128;
  localparam int RC6_BYTES   = 16;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } ld_state_t;

  // Bit offset of the low bit of byte k inside the 128-bit block.
  // swap=1: word k/4 counted from the top, lane k%4 counted from its
  // bottom, which byte-reverses each 32-bit word of the NESSIE stream.
  // swap=0: plain big-endian packing, byte 0 at [127:120].
  function automatic logic [6:0] rc6_byte_lane(
    input logic [3:0] k,
    input logic       swap
  );
    int off;
    if (swap)
      off = 96 - 32 * int'(k[3:2]) + 8 * int'(k[1:0]);
    else
      off = 120 - 8 * int'(k);
    return 7'(off);
  endfunction

endpackage

// File: rtl/rc6_lane_writer.sv
// Byte-enable demux and 128-bit block register.
// Ports: clk, rst, clear, wr_en, idx (byte index), din (byte), dout (block).
module rc6_lane_writer
  import rc6_pkg::*;
#(
  parameter bit SWAP_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [3:0]             idx,
  input  logic [7:0]             din,
  output logic [RC6_BLOCK_W-1:0] dout
);

  logic [6:0] off;

  assign off = rc6_byte_lane(idx, SWAP_EN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dout <= '0;
    else if (clear)
      dout <= '0;
    else if (wr_en)
      dout[off +: 8] <= din;
  end

endmodule

// File: rtl/rc6_data_in_loader.sv
// Byte-serial loader: assembles 16 NESSIE-order bytes into a core block.
// Ports: inClk, inReset, inClear, inByte/inByteValid/outByteReady (byte
// side), outData/outDataValid/inDataTaken (block side).
module rc6_data_in_loader
  import rc6_pkg::*;
#(
  parameter bit SWAP_EN = 1'b1
) (
  input  logic                   inClk,
  input  logic                   inReset,
  input  logic                   inClear,
  input  logic [7:0]             inByte,
  input  logic                   inByteValid,
  output logic                   outByteReady,
  output logic [RC6_BLOCK_W-1:0] outData,
  output logic                   outDataValid,
  input  logic                   inDataTaken
);

  ld_state_t  state;
  ld_state_t  state_nxt;
  logic [3:0] count;
  logic       accept;

  assign accept = inByteValid && outByteReady;

  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset)
      state <= FILL;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (inClear) begin
      state_nxt = FILL;
    end else begin
      unique case (state)
        FILL: if (accept && count == 4'd15) state_nxt = FULL;
        FULL: if (inDataTaken) state_nxt = FILL;
      endcase
    end
  end

  always_comb begin
    outByteReady = (state == FILL);
    outDataValid = (state == FULL);
  end

  // Counter wraps 15 -> 0 on the byte that completes the block.
  always_ff @(posedge inClk or posedge inReset) begin
    if (inReset)
      count <= '0;
    else if (inClear)
      count <= '0;
    else if (accept)
      count <= count + 4'd1;
  end

  rc6_lane_writer #(
    .SWAP_EN(SWAP_EN)
  ) u_lane (
    .clk  (inClk),
    .rst  (inReset),
    .clear(inClear),
    .wr_en(accept && !inClear),
    .idx  (count),
    .din  (inByte),
    .dout (outData)
  );

endmodule
